// File: rtl/bit_count_checker.sv
// Monitors a free-running WIDTH-bit counter: checks each qualified sample is the previous plus one,
// flags and counts step errors, and counts wrap-arounds. All outputs are registered.
module bit_count_checker #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              en,
  input  logic              clr_err,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WIDTH-1:0]  last_val,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StTrack = 2'b01,
    StFault = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic                wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                err_q, err_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]    last_val_q, last_val_d;
  logic [WIDTH-1:0]    expected;

  // Modulo-2^WIDTH successor of the last accepted sample.
  assign expected = last_val_q + WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    wrap_pulse_d = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;
    err_d        = err_q;
    err_cnt_d    = err_cnt_q;
    last_val_d   = last_val_q;

    if (clr_err) begin
      // Clear wins over a same-cycle sample, which is dropped.
      err_d     = 1'b0;
      err_cnt_d = '0;
      state_d   = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (en) begin
            last_val_d = cnt_in;
            state_d    = StTrack;
          end
        end
        StTrack, StFault: begin
          if (en) begin
            last_val_d = cnt_in;
            if (cnt_in == expected) begin
              if (expected == '0) begin
                wrap_pulse_d = 1'b1;
                if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
              end
            end else begin
              err_d   = 1'b1;
              state_d = StFault;
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      last_val_q   <= '0;
    end else begin
      state_q      <= state_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      last_val_q   <= last_val_d;
    end
  end

  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
  assign last_val   = last_val_q;
  assign state      = state_q;

endmodule

// File: tb/tb_bit_count_checker.sv
// Directed bench for bit_count_checker: a default-width instance and a 2-bit-counter instance
// share stimulus; the small one is used for saturation checks.
module tb_bit_count_checker;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       en;
  logic       clr_err;

  logic       wrap_pulse_b, err_b;
  logic [7:0] wrap_cnt_b, err_cnt_b;
  logic [3:0] last_val_b;
  logic [1:0] state_b;

  logic       wrap_pulse_s, err_s;
  logic [1:0] wrap_cnt_s, err_cnt_s;
  logic [3:0] last_val_s;
  logic [1:0] state_s;

  int n_checks = 0;
  int n_errors = 0;
  int pulses_b = 0;
  int pulses_s = 0;

  bit_count_checker #(.WIDTH(4), .WRAP_W(8), .ERR_W(8)) u_big (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .en         (en),
    .clr_err    (clr_err),
    .wrap_pulse (wrap_pulse_b),
    .wrap_cnt   (wrap_cnt_b),
    .err        (err_b),
    .err_cnt    (err_cnt_b),
    .last_val   (last_val_b),
    .state      (state_b)
  );

  bit_count_checker #(.WIDTH(4), .WRAP_W(2), .ERR_W(2)) u_small (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .en         (en),
    .clr_err    (clr_err),
    .wrap_pulse (wrap_pulse_s),
    .wrap_cnt   (wrap_cnt_s),
    .err        (err_s),
    .err_cnt    (err_cnt_s),
    .last_val   (last_val_s),
    .state      (state_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic e, input logic [3:0] c, input logic clr);
    en      = e;
    cnt_in  = c;
    clr_err = clr;
    @(posedge clk);
    #1;
    if (wrap_pulse_b) pulses_b++;
    if (wrap_pulse_s) pulses_s++;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, 32'(state_b), 32'd0);
    check_eq({tag, "_pulse"}, 32'(wrap_pulse_b), 32'd0);
    check_eq({tag, "_wrapcnt"}, 32'(wrap_cnt_b), 32'd0);
    check_eq({tag, "_err"}, 32'(err_b), 32'd0);
    check_eq({tag, "_errcnt"}, 32'(err_cnt_b), 32'd0);
    check_eq({tag, "_lastval"}, 32'(last_val_b), 32'd0);
  endtask

  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    clr_err = 1'b0;
    cnt_in  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Clean count 0..15,0..3: one wrap, on the cycle after the second 0.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'(i % 16), 1'b0);
      if (i == 0) check_eq("first_state", 32'(state_b), 32'd1);
      if (i == 16) check_eq("wrap_pulse_hi", 32'(wrap_pulse_b), 32'd1);
      if (i == 17) check_eq("wrap_pulse_lo", 32'(wrap_pulse_b), 32'd0);
    end
    check_eq("clean_pulses", 32'(pulses_b), 32'd1);
    check_eq("clean_wrapcnt", 32'(wrap_cnt_b), 32'd1);
    check_eq("clean_err", 32'(err_b), 32'd0);
    check_eq("clean_lastval", 32'(last_val_b), 32'd3);
    check_eq("clean_state", 32'(state_b), 32'd1);

    // Skipped value 5.
    step(1'b1, 4'd4, 1'b0);
    step(1'b1, 4'd6, 1'b0);
    check_eq("skip_err", 32'(err_b), 32'd1);
    check_eq("skip_errcnt", 32'(err_cnt_b), 32'd1);
    check_eq("skip_state", 32'(state_b), 32'd2);
    step(1'b1, 4'd7, 1'b0);
    check_eq("skip_after_errcnt", 32'(err_cnt_b), 32'd1);
    check_eq("skip_after_lastval", 32'(last_val_b), 32'd7);

    // Repeated value.
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    check_eq("hold_errcnt", 32'(err_cnt_b), 32'd2);
    check_eq("hold_err", 32'(err_b), 32'd1);

    // Clear, then an upstream reset mid-count (5 -> 0).
    step(1'b0, 4'd0, 1'b1);
    check_eq("clr_state", 32'(state_b), 32'd0);
    check_eq("clr_errcnt", 32'(err_cnt_b), 32'd0);
    check_eq("clr_lastval", 32'(last_val_b), 32'd9);
    step(1'b1, 4'd4, 1'b0);
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd0, 1'b0);
    check_eq("midrst_nowrap", 32'(wrap_pulse_b), 32'd0);
    step(1'b1, 4'd1, 1'b0);
    check_eq("midrst_errcnt", 32'(err_cnt_b), 32'd1);
    check_eq("midrst_state", 32'(state_b), 32'd2);
    step(1'b1, 4'd2, 1'b1);
    check_eq("clr2_err", 32'(err_b), 32'd0);
    check_eq("clr2_errcnt", 32'(err_cnt_b), 32'd0);
    check_eq("clr2_state", 32'(state_b), 32'd0);
    check_eq("clr2_lastval", 32'(last_val_b), 32'd1);
    check_eq("clr2_wrapcnt", 32'(wrap_cnt_b), 32'd1);
    step(1'b1, 4'd3, 1'b0);
    check_eq("resync_state", 32'(state_b), 32'd1);
    check_eq("resync_lastval", 32'(last_val_b), 32'd3);
    check_eq("resync_err", 32'(err_b), 32'd0);

    // en=0 holds everything.
    step(1'b0, 4'd7, 1'b0);
    check_eq("hold_en_lastval", 32'(last_val_b), 32'd3);
    check_eq("hold_en_state", 32'(state_b), 32'd1);

    // Four errors, then asynchronous reset between edges.
    for (int i = 0; i < 4; i++) step(1'b1, 4'd9, 1'b0);
    check_eq("pre_arst_errcnt", 32'(err_cnt_b), 32'd4);
    check_eq("pre_arst_state", 32'(state_b), 32'd2);
    #3;
    rst = 1'b0;
    #1;
    check_all_zero("arst");
    check_eq("arst_small_state", 32'(state_s), 32'd0);
    #2;
    rst = 1'b1;

    // Saturation on the 2-bit counters: five full wraps, then five repeats.
    pulses_b = 0;
    pulses_s = 0;
    step(1'b1, 4'd0, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      step(1'b1, 4'(k % 16), 1'b0);
      if (k == 80) check_eq("sat_pulse_last", 32'(wrap_pulse_s), 32'd1);
    end
    check_eq("sat_pulses_s", 32'(pulses_s), 32'd5);
    check_eq("sat_wrapcnt_s", 32'(wrap_cnt_s), 32'd3);
    check_eq("sat_wrapcnt_b", 32'(wrap_cnt_b), 32'd5);
    for (int k = 0; k < 5; k++) step(1'b1, 4'd0, 1'b0);
    check_eq("sat_errcnt_s", 32'(err_cnt_s), 32'd3);
    check_eq("sat_errcnt_b", 32'(err_cnt_b), 32'd5);
    check_eq("sat_err_s", 32'(err_s), 32'd1);
    check_eq("sat_lastval_s", 32'(last_val_s), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
